exp4_trena_uc: RTL and testbench

//  Control unit (FSM) that sequences the trena datapath through one full cycle:

---
 rtl/exp4_trena_uc_if.sv | 23 ++
 rtl/exp4_trena_uc.sv | 79 +++++++
 tb/tb_exp4_trena_uc.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/exp4_trena_uc_if.sv
// exp4_trena_uc_if: signal bundle between the trena control unit and its datapath.
interface exp4_trena_uc_if;
    logic       mensurar;
    logic       modo_continuo;
    logic       pronto_medida;
    logic       pronto_transmissao;
    logic       fim_serial;
    logic       medir;
    logic       partida_serial;
    logic       zera;
    logic       conta_ascii;
    logic       pronto;
    logic       erro;
    logic [3:0] db_estado;
    modport master (
        output mensurar, modo_continuo, pronto_medida, pronto_transmissao, fim_serial,
        input  medir, partida_serial, zera, conta_ascii, pronto, erro, db_estado
    );
    modport slave (
        input  mensurar, modo_continuo, pronto_medida, pronto_transmissao, fim_serial,
        output medir, partida_serial, zera, conta_ascii, pronto, erro, db_estado
    );
endinterface

// File: rtl/exp4_trena_uc.sv
// exp4_trena_uc: Moore control unit sequencing measure -> 4-char serial TX, with
// measurement timeout and optional periodic re-trigger.
module exp4_trena_uc #(
    parameter int TIMEOUT_MEDIDA = 2_500_000,
    parameter int INTERVALO      = 25_000_000,
    parameter int CW             = 26
) (
    input logic             clock,
    input logic             reset,
    exp4_trena_uc_if.slave  bus
);
    typedef enum logic [3:0] {
        INICIAL          = 4'h0,
        PREPARACAO       = 4'h1,
        MEDIR            = 4'h2,
        ESPERA_MEDIDA    = 4'h3,
        TRANSMITE        = 4'h4,
        ESPERA_TX        = 4'h5,
        PROXIMO          = 4'h6,
        FINAL            = 4'h7,
        ESPERA_INTERVALO = 4'h8,
        ERRO             = 4'hF
    } state_t;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    // saturating increment so a stuck wait never wraps back into range
    assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= INICIAL;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    always_comb begin
        state_n = INICIAL;
        cnt_n   = cnt;
        case (state)
            INICIAL:       state_n = bus.mensurar ? PREPARACAO : INICIAL;
            PREPARACAO: begin
                state_n = MEDIR;
                cnt_n   = '0;
            end
            MEDIR: begin
                state_n = ESPERA_MEDIDA;
                cnt_n   = '0;
            end
            ESPERA_MEDIDA: begin
                state_n = bus.pronto_medida ? TRANSMITE :
                          cnt == CW'(TIMEOUT_MEDIDA - 1) ? ERRO : ESPERA_MEDIDA;
                cnt_n   = cnt_inc;
            end
            TRANSMITE:     state_n = ESPERA_TX;
            ESPERA_TX:     state_n = !bus.pronto_transmissao ? ESPERA_TX :
                                     bus.fim_serial ? FINAL : PROXIMO;
            PROXIMO:       state_n = TRANSMITE;
            FINAL: begin
                state_n = bus.modo_continuo ? ESPERA_INTERVALO : INICIAL;
                cnt_n   = '0;
            end
            ESPERA_INTERVALO: begin
                state_n = !bus.modo_continuo ? INICIAL :
                          cnt == CW'(INTERVALO - 1) ? PREPARACAO : ESPERA_INTERVALO;
                cnt_n   = cnt_inc;
            end
            ERRO:          state_n = bus.mensurar ? PREPARACAO : ERRO;
            default:       state_n = INICIAL;
        endcase
    end
    assign bus.zera           = state == PREPARACAO;
    assign bus.medir          = state == MEDIR;
    assign bus.partida_serial = state == TRANSMITE;
    assign bus.conta_ascii    = state == PROXIMO;
    assign bus.pronto         = state == FINAL;
    assign bus.erro           = state == ERRO;
    assign bus.db_estado      = state;
endmodule

// File: tb/tb_exp4_trena_uc.sv
// tb_exp4_trena_uc: directed bench with a behavioural datapath model and an
// event scoreboard checked by an independent monitor.
module tb_exp4_trena_uc;
    localparam byte EZ = 8'h5A, EM = 8'h4D, EP = 8'h50, EC = 8'h43, ED = 8'h44, EE = 8'h45;
    localparam int S_Z = 0, S_M = 1, S_P = 2, S_C = 3, S_D = 4, S_E = 5, S_TX = 6;
    logic clock = 0;
    logic reset = 0;
    int   nerr = 0, nchk = 0;
    byte  exp_q[$];
    int   meas_delay = 20, tx_delay = 30;
    int   cz = 0, cm = 0, cp = 0, cc = 0, cd = 0, ce = 0;
    exp4_trena_uc_if bus();
    exp4_trena_uc #(.TIMEOUT_MEDIDA(100), .INTERVALO(50), .CW(26)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
    always #5 clock = ~clock;
    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clock);
        #2;
    endtask
    function automatic logic sig(input int w);
        case (w)
            S_Z:  return bus.zera;
            S_M:  return bus.medir;
            S_P:  return bus.partida_serial;
            S_C:  return bus.conta_ascii;
            S_D:  return bus.pronto;
            S_E:  return bus.erro;
            S_TX: return bus.pronto_transmissao;
            default: return 1'b0;
        endcase
    endfunction
    function automatic int outs();
        return int'({bus.zera, bus.medir, bus.partida_serial, bus.conta_ascii, bus.pronto, bus.erro});
    endfunction
    task automatic wait_sig(input int w, input int lim, output int n);
        n = 0;
        while (!sig(w) && n < lim) begin
            step();
            n++;
        end
        check($sformatf("wait_sig%0d", w), int'(sig(w)), 1);
    endtask
    task automatic push_cycle();
        exp_q.push_back(EZ);
        exp_q.push_back(EM);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(EP);
            if (i < 3) exp_q.push_back(EC);
        end
        exp_q.push_back(ED);
    endtask
    task automatic pulse_mensurar();
        bus.mensurar = 1;
        step();
        bus.mensurar = 0;
    endtask
    task automatic got(input byte c);
        if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL sb_event: got %0d expected none", c);
        end else begin
            check("sb_event", c, exp_q.pop_front());
        end
    endtask
    // datapath model: measurement/TX completion delays and the char selector
    initial begin
        int mcnt, tcnt, sel;
        mcnt = 0; tcnt = 0; sel = 0;
        bus.pronto_medida = 0;
        bus.pronto_transmissao = 0;
        bus.fim_serial = 0;
        forever begin
            @(posedge clock);
            #1;
            bus.pronto_medida = 0;
            bus.pronto_transmissao = 0;
            if (!reset) begin
                mcnt = 0; tcnt = 0; sel = 0;
            end else begin
                if (mcnt > 0) begin
                    mcnt--;
                    if (mcnt == 0) bus.pronto_medida = 1;
                end
                if (tcnt > 0) begin
                    tcnt--;
                    if (tcnt == 0) bus.pronto_transmissao = 1;
                end
                if (bus.medir && meas_delay > 0) mcnt = meas_delay;
                if (bus.partida_serial) tcnt = tx_delay;
                if (bus.zera) sel = 0;
                else if (bus.conta_ascii) sel++;
            end
            bus.fim_serial = sel == 3;
        end
    end
    initial begin
        logic erro_q;
        erro_q = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                erro_q = 0;
            end else begin
                if (bus.zera) begin cz++; got(EZ); end
                if (bus.medir) begin cm++; got(EM); end
                if (bus.partida_serial) begin cp++; got(EP); end
                if (bus.conta_ascii) begin cc++; got(EC); end
                if (bus.pronto) begin cd++; got(ED); end
                if (bus.erro && !erro_q) begin ce++; got(EE); end
                erro_q = bus.erro;
            end
        end
    end
    initial begin
        int n, z0, m0, p0, c0, d0, e0;
        bus.mensurar = 0;
        bus.modo_continuo = 0;
        #2;
        check("rst_db", bus.db_estado, 0);
        check("rst_outs", outs(), 0);
        step();
        reset = 1;
        step();
        check("init_db", bus.db_estado, 0);
        // async reset in the middle of ESPERA_TX
        exp_q.push_back(EZ); exp_q.push_back(EM); exp_q.push_back(EP);
        pulse_mensurar();
        wait_sig(S_P, 100, n);
        step();
        step();
        check("t1_esptx", bus.db_estado, 5);
        #1 reset = 0;
        #1;
        check("t1_db", bus.db_estado, 0);
        check("t1_outs", outs(), 0);
        step();
        reset = 1;
        step();
        check("t1_init", bus.db_estado, 0);
        check("t1_queue", exp_q.size(), 0);
        // full successful cycle
        push_cycle();
        z0 = cz; m0 = cm; p0 = cp; c0 = cc; d0 = cd;
        pulse_mensurar();
        wait_sig(S_M, 10, n);
        check("t2_lat_medir", n + 1, 2);
        for (int i = 0; i < 4; i++) begin
            wait_sig(S_TX, 200, n);
            if (i < 3) step();
        end
        step();
        check("t2_lat_pronto", int'(bus.pronto), 1);
        step();
        check("t2_db_end", bus.db_estado, 0);
        check("t2_zera", cz - z0, 1);
        check("t2_medir", cm - m0, 1);
        check("t2_partida", cp - p0, 4);
        check("t2_conta", cc - c0, 3);
        check("t2_pronto", cd - d0, 1);
        // measurement timeout, then retry
        meas_delay = -1;
        exp_q.push_back(EZ); exp_q.push_back(EM); exp_q.push_back(EE);
        pulse_mensurar();
        wait_sig(S_M, 10, n);
        step();
        check("t3_espmed", bus.db_estado, 3);
        wait_sig(S_E, 300, n);
        check("t3_timeout", n, 100);
        check("t3_db", bus.db_estado, 15);
        meas_delay = 20;
        push_cycle();
        pulse_mensurar();
        check("t3_retry_db", bus.db_estado, 1);
        check("t3_retry_erro", int'(bus.erro), 0);
        wait_sig(S_D, 1000, n);
        step();
        // pronto_medida on the last allowed cycle beats the timeout
        meas_delay = 100;
        push_cycle();
        e0 = ce;
        pulse_mensurar();
        wait_sig(S_M, 10, n);
        step();
        wait_sig(S_P, 300, n);
        check("t4_edge", n, 100);
        check("t4_db", bus.db_estado, 4);
        wait_sig(S_D, 1000, n);
        step();
        check("t4_no_erro", ce - e0, 0);
        // continuous mode
        meas_delay = 20;
        bus.modo_continuo = 1;
        push_cycle();
        push_cycle();
        pulse_mensurar();
        wait_sig(S_D, 1000, n);
        step();
        check("t5_espint", bus.db_estado, 8);
        wait_sig(S_Z, 200, n);
        check("t5_intervalo", n, 50);
        wait_sig(S_D, 1000, n);
        step();
        check("t5_espint2", bus.db_estado, 8);
        for (int i = 0; i < 5; i++) step();
        bus.modo_continuo = 0;
        step();
        check("t5_abort", bus.db_estado, 0);
        check("t5_queue", exp_q.size(), 0);
        // mensurar held high for a whole cycle
        push_cycle();
        m0 = cm;
        bus.mensurar = 1;
        wait_sig(S_D, 1000, n);
        step();
        check("t6_db", bus.db_estado, 0);
        check("t6_medir", cm - m0, 1);
        bus.mensurar = 0;
        step();
        step();
        check("t6_idle", bus.db_estado, 0);
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
